pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: program counter width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: value loaded into State on reset.
REQ-003 Parameter STEP, default 4: sequential increment.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of 2, at least 2.
REQ-005 Port Clk, input, 1: single clock; all state updates on posedge.
REQ-006 Port Reset, input, 1: asynchronous, active-high reset.
REQ-007 Port Stall, input, 1: hold all state when 1.
REQ-008 Port Sel, input, 3: next-PC mode select.
REQ-009 Port Offset, input, WIDTH: signed two's-complement branch displacement.
REQ-010 Port Target, input, WIDTH: absolute jump or call destination.
REQ-011 Port State, output reg, WIDTH: current PC.
REQ-012 Port NextSeq, output, WIDTH: combinational State+STEP, mod 2^WIDTH.
REQ-013 Port RasEmpty / RasFull, output, 1 each: stack occupancy is 0 / RAS_DEPTH.
REQ-014 Port RasErr, output reg, 1: sticky stack-misuse flag.

Function
REQ-015 Update priority SHALL be Reset > Stall > Sel.
REQ-016 Sel=0 SEQ SHALL set State <= State+STEP.
REQ-017 Sel=1 BRANCH SHALL set State <= State+Offset, signed.
REQ-018 Sel=2 JUMP SHALL set State <= Target.
REQ-019 Sel=3 CALL SHALL set State <= Target and push NextSeq onto the RAS in the same edge.
REQ-020 Sel=4 RET SHALL set State <= RAS top and pop it in the same edge.
REQ-021 Sel=5..7 SHALL hold State and set RasErr.
REQ-022 All PC arithmetic SHALL be modulo 2^WIDTH; wrap-around is silent; no alignment forcing on Target or Offset.
REQ-023 Latency: a mode applied before a posedge SHALL be visible on State immediately after that edge, with no bubbles.
REQ-024 RAS SHALL be LIFO with an occupancy count in range 0..RAS_DEPTH.
REQ-025 CALL when full SHALL overwrite the oldest entry (circular), keep count=RAS_DEPTH, and set RasErr.
REQ-026 RET when empty SHALL set State <= NextSeq, keep count=0, and set RasErr.
REQ-027 Stall=1 SHALL freeze State, RAS contents, count and RasErr regardless of Sel.
REQ-028 RasErr SHALL clear only on Reset.
REQ-029 RasEmpty and RasFull SHALL be combinational from count.

Reset
REQ-030 Reset assertion SHALL, without a clock edge, set State=RESET_VECTOR, count=0, RasErr=0; RAS entry contents are don't-care.
REQ-031 While Reset=1, State SHALL hold RESET_VECTOR irrespective of Clk, Stall and Sel.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight CALL/RET; the first edge after release SHALL apply Sel normally.

Verification
All scenarios use WIDTH=32, RESET_VECTOR=0x100, STEP=4, RAS_DEPTH=4.
REQ-033 Reset pulse between clock edges -> State=0x100 before the next edge; release, then 3x SEQ -> 0x104, 0x108, 0x10C.
REQ-034 BRANCH Offset=0xFFFFFFF8 from 0x10C -> 0x104; JUMP Target=0xFFFFFFFC, then SEQ -> 0x00000000.
REQ-035 CALL Target=0x200 from 0x104 -> State=0x200, RasEmpty=0; RET -> State=0x108, RasEmpty=1, RasErr=0.
REQ-036 5 nested CALLs, pushing 0xA04, 0xB04, 0xC04, 0xD04, 0xE04 -> RasFull after the 4th, RasErr=1 after the 5th; 4 RETs -> 0xE04, 0xD04, 0xC04, 0xB04, then RasEmpty=1.
REQ-037 Stall=1 with Sel=CALL for 3 edges -> State, count and RasEmpty unchanged.
REQ-038 RET when empty from 0x300 -> State=0x304, RasErr=1; RasErr stays 1 through further SEQ/CALL/RET until Reset.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with a small return-address stack (RAS)
//
// Computes the next program counter each cycle from one of five modes:
// sequential step, PC-relative branch, absolute jump, call (jump and push
// return address) and return (pop return address). The RAS is a circular
// LIFO. When it is full, a call overwrites the oldest entry. A return on an
// empty stack falls through to the sequential address. Either misuse raises
// a sticky error flag, and so does an undefined Sel code.
//
// Parameters
//   WIDTH         program counter width in bits
//   RESET_VECTOR  value State takes on reset
//   STEP          sequential increment
//   RAS_DEPTH     return-address-stack entries (power of 2, >= 2)
//
// Ports
//   Clk       in   clock, all state changes on the rising edge
//   Reset     in   asynchronous active-high reset
//   Stall     in   freeze all state when high
//   Sel       in   [2:0] next-PC mode: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET
//   Offset    in   [WIDTH-1:0] signed branch displacement
//   Target    in   [WIDTH-1:0] absolute jump / call destination
//   State     out  [WIDTH-1:0] current program counter
//   NextSeq   out  [WIDTH-1:0] State + STEP (combinational)
//   RasEmpty  out  stack occupancy is zero
//   RasFull   out  stack occupancy is RAS_DEPTH
//   RasErr    out  sticky stack-misuse / illegal-mode flag
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic [2:0]       Sel,
    input  logic [WIDTH-1:0] Offset,
    input  logic [WIDTH-1:0] Target,
    output logic [WIDTH-1:0] State,
    output logic [WIDTH-1:0] NextSeq,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasErr
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_CALL   = 3'd3;
    localparam logic [2:0] SEL_RET    = 3'd4;

    // Stack storage. It is kept small and read asynchronously because a
    // return has to see the top entry in the same cycle it is popped.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    // ras_ptr_reg is the next slot to write. The top of the stack is at
    // ras_ptr_reg-1. Because the depth is a power of two, the pointer wraps
    // on its own. A call on a full stack therefore lands on the oldest entry.
    logic [PTR_W-1:0] ras_ptr_reg;
    logic [PTR_W-1:0] ras_ptr_next;
    logic [CNT_W-1:0] ras_cnt_reg;
    logic [CNT_W-1:0] ras_cnt_next;
    logic [PTR_W-1:0] ras_top_idx;
    logic [WIDTH-1:0] state_next;
    logic             err_next;
    logic             push_req;
    logic             push_en;

    assign NextSeq     = State + WIDTH'(STEP);
    assign RasEmpty    = (ras_cnt_reg == CNT_ZERO);
    assign RasFull     = (ras_cnt_reg == CNT_MAX);
    assign ras_top_idx = ras_ptr_reg - PTR_ONE;

    // Next-state decode. Stall is applied at the registers, not here.
    always_comb begin
        state_next   = State;
        ras_ptr_next = ras_ptr_reg;
        ras_cnt_next = ras_cnt_reg;
        err_next     = RasErr;
        push_req     = 1'b0;
        case (Sel)
            SEL_SEQ: begin
                state_next = NextSeq;
            end
            SEL_BRANCH: begin
                // In two's complement, the signed add is the same as the
                // unsigned add.
                state_next = State + Offset;
            end
            SEL_JUMP: begin
                state_next = Target;
            end
            SEL_CALL: begin
                state_next   = Target;
                push_req     = 1'b1;
                ras_ptr_next = ras_ptr_reg + PTR_ONE;
                if (ras_cnt_reg == CNT_MAX) begin
                    err_next = 1'b1;
                end else begin
                    ras_cnt_next = ras_cnt_reg + CNT_ONE;
                end
            end
            SEL_RET: begin
                if (ras_cnt_reg == CNT_ZERO) begin
                    state_next = NextSeq;
                    err_next   = 1'b1;
                end else begin
                    state_next   = ras_mem[ras_top_idx];
                    ras_ptr_next = ras_top_idx;
                    ras_cnt_next = ras_cnt_reg - CNT_ONE;
                end
            end
            default: begin
                err_next = 1'b1;
            end
        endcase
    end

    // The entry write is gated by Reset so that a call in flight when reset
    // arrives leaves no trace.
    assign push_en = push_req && !Stall && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            State       <= RESET_VECTOR;
            ras_ptr_reg <= '0;
            ras_cnt_reg <= '0;
            RasErr      <= 1'b0;
        end else if (!Stall) begin
            State       <= state_next;
            ras_ptr_reg <= ras_ptr_next;
            ras_cnt_reg <= ras_cnt_next;
            RasErr      <= err_next;
        end
    end

    // Entry contents do not need a reset. Occupancy alone defines validity.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            ras_mem[ras_ptr_reg] <= NextSeq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit
//
// This bench runs the directed scenarios, then applies random traffic.
// Every result is compared against a queue-based reference model of the PC
// and its return-address stack.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic [2:0]  Sel;
    logic [31:0] Offset;
    logic [31:0] Target;
    logic [31:0] State;
    logic [31:0] NextSeq;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasErr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model.
    logic [31:0] m_state;
    logic [31:0] m_ras[$];
    logic        m_err;

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (RV),
        .STEP         (4),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Stall    (Stall),
        .Sel      (Sel),
        .Offset   (Offset),
        .Target   (Target),
        .State    (State),
        .NextSeq  (NextSeq),
        .RasEmpty (RasEmpty),
        .RasFull  (RasFull),
        .RasErr   (RasErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, State, m_state);
        check({tag, "_nextseq"}, NextSeq, m_state + 32'd4);
        check({tag, "_empty"}, {31'd0, RasEmpty}, {31'd0, m_ras.size() == 0});
        check({tag, "_full"}, {31'd0, RasFull}, {31'd0, m_ras.size() == DEPTH});
        check({tag, "_err"}, {31'd0, RasErr}, {31'd0, m_err});
    endtask

    task automatic model_reset();
        m_state = RV;
        m_ras.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic [2:0] sel,
                              input logic [31:0] off, input logic [31:0] tgt);
        logic [31:0] ret_addr;
        if (st) return;
        case (sel)
            3'd0: m_state = m_state + 32'd4;
            3'd1: m_state = m_state + off;
            3'd2: m_state = tgt;
            3'd3: begin
                ret_addr = m_state + 32'd4;
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back(ret_addr);
                m_state = tgt;
            end
            3'd4: begin
                if (m_ras.size() == 0) begin
                    m_state = m_state + 32'd4;
                    m_err   = 1'b1;
                end else begin
                    m_state = m_ras.pop_back();
                end
            end
            default: m_err = 1'b1;
        endcase
    endtask

    // Drive one operation, let it take effect on the next edge, then check it.
    task automatic do_op(input logic st, input logic [2:0] sel,
                         input logic [31:0] off, input logic [31:0] tgt);
        Stall  = st;
        Sel    = sel;
        Offset = off;
        Target = tgt;
        model_step(st, sel, off, tgt);
        @(posedge Clk);
        #1;
        $display("op stall=%0d sel=%0d off=%08h tgt=%08h -> State=%08h empty=%0d full=%0d err=%0d",
                 st, sel, off, tgt, State, RasEmpty, RasFull, RasErr);
        check_all("op");
    endtask

    // Called one time unit after a rising edge. This asserts Reset between
    // edges, checks the asynchronous effect, and optionally holds Reset
    // across some edges with a CALL pending. It releases Reset between edges.
    task automatic pulse_reset(input int edges);
        Sel    = 3'd3;
        Target = 32'h0000_0DEC;
        Stall  = 1'($urandom_range(0, 1));
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        $display("reset asserted -> State=%08h empty=%0d err=%0d", State, RasEmpty, RasErr);
        check_all("rst_async");
        for (int i = 0; i < edges; i++) begin
            @(posedge Clk);
            #1;
            check_all("rst_hold");
        end
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        int          r;
        logic [2:0]  sel;

        Reset  = 1'b1;
        Stall  = 1'b0;
        Sel    = 3'd0;
        Offset = '0;
        Target = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("por");
        #2;
        Reset = 1'b0;

        // Reset between edges, then sequential steps.
        @(posedge Clk);
        #1;
        pulse_reset(0);
        check("rst_vec", State, 32'h100);
        do_op(0, 3'd0, 0, 0); check("seq1", State, 32'h104);
        do_op(0, 3'd0, 0, 0); check("seq2", State, 32'h108);
        do_op(0, 3'd0, 0, 0); check("seq3", State, 32'h10C);

        // Negative branch, jump near the top, wrap on the next step.
        do_op(0, 3'd1, 32'hFFFF_FFF8, 0); check("br_neg", State, 32'h104);
        do_op(0, 3'd2, 0, 32'hFFFF_FFFC); check("jmp_top", State, 32'hFFFF_FFFC);
        do_op(0, 3'd0, 0, 0);             check("seq_wrap", State, 32'h0);

        // Simple call and return.
        do_op(0, 3'd2, 0, 32'h104);
        do_op(0, 3'd3, 0, 32'h200);
        check("call_state", State, 32'h200);
        check("call_empty", {31'd0, RasEmpty}, 32'd0);
        do_op(0, 3'd4, 0, 0);
        check("ret_state", State, 32'h108);
        check("ret_empty", {31'd0, RasEmpty}, 32'd1);
        check("ret_err", {31'd0, RasErr}, 32'd0);

        // Five nested calls: the stack overflows and the oldest entry is lost.
        do_op(0, 3'd2, 0, 32'hA00);
        for (int i = 0; i < 5; i++) begin
            do_op(0, 3'd3, 0, 32'hB00 + 32'(i) * 32'h100);
            if (i == 3) check("full_after4", {31'd0, RasFull}, 32'd1);
        end
        check("ovf_err", {31'd0, RasErr}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_op(0, 3'd4, 0, 0);
            check("nested_ret", State, 32'hE04 - 32'(i) * 32'h100);
        end
        check("nested_empty", {31'd0, RasEmpty}, 32'd1);

        // A stall with CALL on Sel freezes everything.
        do_op(0, 3'd3, 0, 32'h600);
        saved = State;
        for (int i = 0; i < 3; i++) begin
            do_op(1, 3'd3, 0, 32'h500);
            check("stall_state", State, saved);
            check("stall_empty", {31'd0, RasEmpty}, 32'd0);
        end

        // Reset held across edges with a CALL pending, then return on an
        // empty stack.
        pulse_reset(2);
        do_op(0, 3'd4, 0, 0);
        check("rst_discard_call", {31'd0, RasErr}, 32'd1);
        do_op(0, 3'd2, 0, 32'h300);
        do_op(0, 3'd4, 0, 0);
        check("ret_empty_state", State, 32'h304);
        check("ret_empty_err", {31'd0, RasErr}, 32'd1);
        do_op(0, 3'd0, 0, 0);        check("err_sticky_seq", {31'd0, RasErr}, 32'd1);
        do_op(0, 3'd3, 0, 32'h700);  check("err_sticky_call", {31'd0, RasErr}, 32'd1);
        do_op(0, 3'd4, 0, 0);        check("err_sticky_ret", {31'd0, RasErr}, 32'd1);
        pulse_reset(0);
        check("err_cleared", {31'd0, RasErr}, 32'd0);

        // Undefined modes hold the PC and raise the error flag.
        do_op(0, 3'd6, 32'h40, 32'h900);
        check("illegal_hold", State, 32'h100);
        check("illegal_err", {31'd0, RasErr}, 32'd1);
        pulse_reset(1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset($urandom_range(0, 2));
            r = $urandom_range(0, 15);
            sel = (r < 14) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
            do_op(($urandom_range(0, 7) == 0), sel, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
